// File: rtl/mux_rr_reg.sv
// Registered N:1 channel multiplexer with valid/ready handshakes on every port.
// The source channel comes from an external select or from round-robin arbitration.
module mux_rr_reg #(
  parameter  int N  = 8,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  input  logic           out_ready
);

  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_ch;
  logic [SW-1:0] r_ptr;

  logic          w_can_acc;
  logic          w_gnt_vld;
  logic [SW-1:0] w_gnt_ch;
  logic          w_take;
  logic [W-1:0]  w_gnt_data;
  logic [SW:0]   w_sum;
  logic [SW-1:0] w_idx;

  assign w_can_acc = !r_out_valid || out_ready;

  // Grant selection: manual select, or first valid channel after r_ptr.
  // In manual mode an out-of-range sel matches no channel and so yields no grant.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_ch  = '0;
    w_sum     = '0;
    w_idx     = '0;
    if (mode) begin
      for (int k = 1; k <= N; k++) begin
        w_sum = {1'b0, r_ptr} + (SW+1)'(k);
        if (w_sum >= (SW+1)'(N))
          w_sum = w_sum - (SW+1)'(N);
        w_idx = w_sum[SW-1:0];
        if (!w_gnt_vld && in_valid[w_idx]) begin
          w_gnt_vld = 1'b1;
          w_gnt_ch  = w_idx;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sel == SW'(i) && in_valid[i]) begin
          w_gnt_vld = 1'b1;
          w_gnt_ch  = SW'(i);
        end
      end
    end
  end

  assign w_take = w_gnt_vld && w_can_acc && !rst;

  always_comb begin
    in_ready   = '0;
    w_gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt_ch == SW'(i)) begin
        in_ready[i] = w_take;
        w_gnt_data  = in_data[i*W +: W];
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= SW'(N-1);
    end else if (w_take) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gnt_data;
      r_out_ch    <= w_gnt_ch;
      r_ptr       <= w_gnt_ch;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Scoreboard bench for mux_rr_reg: an 8-channel instance driven by directed vectors,
// plus a 6-channel instance that exercises the out-of-range select.
module tb_mux_rr_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  in_valid;
  logic [63:0] in_data;
  logic [7:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;
  logic        out_ready;

  logic        mode6;
  logic [2:0]  sel6;
  logic [5:0]  in_valid6;
  logic [47:0] in_data6;
  logic [5:0]  in_ready6;
  logic        out_valid6;
  logic [7:0]  out_data6;
  logic [2:0]  out_ch6;
  logic        out_ready6;

  int n_chk = 0;
  int n_err = 0;
  logic [10:0] q[$];

  always #5 clk = ~clk;

  mux_rr_reg #(.N(8), .W(8)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  mux_rr_reg #(.N(6), .W(8)) u_dut6 (
    .clk(clk), .rst(rst), .mode(mode6), .sel(sel6),
    .in_valid(in_valid6), .in_data(in_data6), .in_ready(in_ready6),
    .out_valid(out_valid6), .out_data(out_data6), .out_ch(out_ch6),
    .out_ready(out_ready6)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: pops one expected {ch,data} per output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL sb_unexpected: got ch=%0d data=%0h, expected no word", out_ch, out_data);
      end else begin
        chk("sb_word", 32'({out_ch, out_data}), 32'(q.pop_front()));
      end
    end
  end

  // One cycle: drive inputs, check in_ready, record the expected transfer, advance.
  task automatic cyc(input logic [7:0] v, input logic m, input logic [2:0] s,
                     input logic ordy, input int exp_ch, input string nm);
    logic [7:0] e;
    in_valid  = v;
    mode      = m;
    sel       = s;
    out_ready = ordy;
    #1;
    e = (exp_ch < 0) ? 8'h00 : (8'h01 << exp_ch);
    chk(nm, 32'(in_ready), 32'(e));
    if (exp_ch >= 0)
      q.push_back({3'(exp_ch), 8'(8'hA0 + exp_ch)});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int rr_all [9]   = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    int rr_25  [4]   = '{2, 5, 2, 5};
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'hA0 + 8'(i);
    for (int i = 0; i < 6; i++) in_data6[i*8 +: 8] = 8'hB0 + 8'(i);
    rst = 1'b1;
    in_valid = 8'hFF; mode = 1'b1; sel = 3'd0; out_ready = 1'b1;
    in_valid6 = 6'h00; mode6 = 1'b0; sel6 = 3'd0; out_ready6 = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    in_valid = 8'h00;
    rst = 1'b0;

    cyc(8'h00, 1'b1, 3'd0, 1'b1, -1, "idle_in_ready");
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    for (int s = 0; s < 8; s++)
      cyc(8'hFF, 1'b0, 3'(s), 1'b1, s, "man_in_ready");
    cyc(8'h7F, 1'b0, 3'd7, 1'b1, -1, "man_sel7_novalid");
    chk("man_drain_valid", 32'(out_valid), 32'd0);

    for (int k = 0; k < 9; k++)
      cyc(8'hFF, 1'b1, 3'd0, 1'b1, rr_all[k], "rr_all_in_ready");
    for (int k = 0; k < 4; k++)
      cyc(8'h24, 1'b1, 3'd0, 1'b1, rr_25[k], "rr_25_in_ready");
    cyc(8'h80, 1'b1, 3'd0, 1'b1, 7, "rr_to7");
    cyc(8'h41, 1'b1, 3'd0, 1'b1, 0, "rr_wrap0");

    for (int k = 0; k < 3; k++) begin
      cyc(8'hFF, 1'b1, 3'd0, 1'b0, -1, "stall_in_ready");
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'hA0);
      chk("stall_ch", 32'(out_ch), 32'd0);
    end
    cyc(8'hFF, 1'b1, 3'd0, 1'b1, 1, "stall_release");
    chk("release_valid", 32'(out_valid), 32'd1);
    chk("release_ch", 32'(out_ch), 32'd1);

    cyc(8'hFF, 1'b1, 3'd0, 1'b1, 2, "ms_rr2");
    cyc(8'hFF, 1'b1, 3'd0, 1'b1, 3, "ms_rr3");
    cyc(8'hFF, 1'b0, 3'd6, 1'b1, 6, "ms_man6");
    cyc(8'hFF, 1'b1, 3'd0, 1'b1, 7, "ms_back_rr7");
    cyc(8'h00, 1'b1, 3'd0, 1'b1, -1, "ms_idle");

    cyc(8'h08, 1'b1, 3'd0, 1'b1, 3, "pre_rst_grant3");
    chk("pre_rst_ch", 32'(out_ch), 32'd3);
    q.delete();
    in_valid = 8'h00;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data", 32'(out_data), 32'd0);
    chk("async_rst_ch", 32'(out_ch), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(8'h00, 1'b1, 3'd0, 1'b1, -1, "post_rst_idle");
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    cyc(8'hFF, 1'b1, 3'd0, 1'b1, 0, "post_rst_ptr");
    cyc(8'h00, 1'b1, 3'd0, 1'b1, -1, "post_rst_drain");

    in_valid6 = 6'h3F; mode6 = 1'b0; sel6 = 3'd2; out_ready6 = 1'b1;
    #1;
    chk("n6_sel2_ready", 32'(in_ready6), 32'h04);
    @(posedge clk); #1;
    chk("n6_word_valid", 32'(out_valid6), 32'd1);
    chk("n6_word_data", 32'(out_data6), 32'hB2);
    sel6 = 3'd7;
    #1;
    chk("n6_sel7_ready", 32'(in_ready6), 32'd0);
    @(posedge clk); #1;
    chk("n6_sel7_drain", 32'(out_valid6), 32'd0);
    chk("n6_sel7_hold", 32'(out_data6), 32'hB2);
    sel6 = 3'd6;
    #1;
    chk("n6_sel6_ready", 32'(in_ready6), 32'd0);
    mode6 = 1'b1;
    #1;
    chk("n6_rr_after2", 32'(in_ready6), 32'h08);
    in_valid6 = 6'h00;
    @(posedge clk); #1;

    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
